bcd_score_counter: RTL

Parametrised multi-digit BCD score counter for the game display chain. It replaces chained single-digit counters with one block of DIGITS cascaded decimal digits. The block adds selectable wrap/saturate mode, a synchronous clear, leading-zero blanking and a session best-score register. It drives the HEX displays directly and exposes packed BCD to game logic.

---
 rtl/score_pkg.sv | 38 +++
 rtl/bcd_digit.sv | 36 +++
 rtl/bcd_score_counter.sv | 80 ++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and seven-segment encoding for the BCD score display chain.
package score_pkg;

    typedef logic [3:0] bcd_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(bcd_t d);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (d)
            4'd0: pat = SEG_0;
            4'd1: pat = SEG_1;
            4'd2: pat = SEG_2;
            4'd3: pat = SEG_3;
            4'd4: pat = SEG_4;
            4'd5: pat = SEG_5;
            4'd6: pat = SEG_6;
            4'd7: pat = SEG_7;
            4'd8: pat = SEG_8;
            4'd9: pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit register: counts 0..9 when enabled, rolls 9 back to 0.
module bcd_digit
    import score_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output bcd_t value,
    output logic is_nine
);

    bcd_t value_q;
    bcd_t value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 4'd0;
        end else if (en) begin
            value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign is_nine = (value_q == 4'd9);

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with wrap/saturate, clear, leading-zero blanking
// and a session best-score register.
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   score,
    output logic [7*DIGITS-1:0]   hex,
    output logic [4*DIGITS-1:0]   best,
    output logic                  carry_out,
    output logic                  at_max
);

    logic [DIGITS-1:0] nine;
    logic [DIGITS:0]   low_nine;   // low_nine[i]: every digit below i is 9
    logic [DIGITS:0]   nz_above;   // nz_above[i]: some digit at or above i is non-zero
    logic              all_nine;
    logic              inc_ok;
    logic [4*DIGITS-1:0] best_q;

    always_comb begin
        low_nine    = '0;
        low_nine[0] = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            low_nine[i+1] = low_nine[i] & nine[i];
        end
    end

    assign all_nine = low_nine[DIGITS];
    assign at_max   = all_nine;
    // Saturate mode suppresses the increment entirely at all-nines.
    assign inc_ok    = inc & ~((SATURATE != 0) & all_nine);
    assign carry_out = (SATURATE == 0) & inc & all_nine & ~clear & ~reset;

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .en      (inc_ok & low_nine[i]),
            .value   (score[4*i +: 4]),
            .is_nine (nine[i])
        );
    end

    // BCD ordering matches numeric ordering, so a plain unsigned compare works.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_q <= '0;
        end else if (score > best_q) begin
            best_q <= score;
        end
    end

    assign best = best_q;

    always_comb begin
        nz_above         = '0;
        nz_above[DIGITS] = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nz_above[i] = nz_above[i+1] | (score[4*i +: 4] != 4'd0);
        end
    end

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_hex
        if (i > 0 && BLANK_LZ != 0) begin : g_blankable
            assign hex[7*i +: 7] = nz_above[i] ? seg7(score[4*i +: 4]) : SEG_BLANK;
        end else begin : g_plain
            assign hex[7*i +: 7] = seg7(score[4*i +: 4]);
        end
    end

endmodule
